// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// The byte-enable constants are used only when DMEM_BYTE_EN is defined.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_t;

    localparam logic [3:0] CYC_SAT = 4'd15;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_HW = 2'b11;

    // Increment that sticks at CYC_SAT instead of wrapping to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == CYC_SAT) ? CYC_SAT : v + 4'd1;
    endfunction

endpackage

// File: rtl/dmem_access_if.sv
// dmem_access_if: request/response and memory-port bundle for dmem_access.
// The slave modport is the responder's view; the master modport is the view
// of whatever drives requests and models the memory.
// With DMEM_BYTE_EN defined the bundle gains i_byte and o_mem_be.
interface dmem_access_if #(
    parameter int ADDR_W = 16
);
    import dmem_pkg::*;

    logic              i_req;
    logic              i_we;
    logic [ADDR_W-1:0] i_addr;
    logic [15:0]       i_wdata;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [15:0]       o_rdata;
    logic [3:0]        o_cycles;
    logic              o_mem_en;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic [15:0]       i_mem_rdata;
    logic              i_mem_ack;
`ifdef DMEM_BYTE_EN
    logic              i_byte;
    logic [1:0]        o_mem_be;
`endif

    modport slave (
`ifdef DMEM_BYTE_EN
        input  i_byte,
        output o_mem_be,
`endif
        input  i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_mem_ack,
        output o_busy, o_done, o_err, o_rdata, o_cycles,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

    modport master (
`ifdef DMEM_BYTE_EN
        output i_byte,
        input  o_mem_be,
`endif
        output i_req, i_we, i_addr, i_wdata, i_mem_rdata, i_mem_ack,
        input  o_busy, o_done, o_err, o_rdata, o_cycles,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/dmem_wait_cnt.sv
// dmem_wait_cnt: 4-bit wait-state counter for one memory access.
// cnt_sat_o is the count including the current cycle (count+1, saturating);
// tmo_o flags the last cycle allowed before the access is abandoned.
module dmem_wait_cnt
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] cnt_sat_o,
    output logic       tmo_o
);

    localparam logic [3:0] TMO_CMP = 4'(TIMEOUT - 1);

    logic [3:0] cnt_q;

    // Clear takes priority so every access starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= 4'd0;
        end else if (inc_i) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign cnt_sat_o = sat_inc(cnt_q);
    assign tmo_o     = (cnt_q == TMO_CMP);

endmodule

// File: rtl/dmem_access.sv
// dmem_access: single-outstanding data-memory responder. Accepts one LDR/STR
// request, holds the memory port stable until ack or timeout, then pulses
// o_done for one cycle. o_busy is decoded from state only, so the stall
// path never sees i_mem_ack combinationally.
// Optional build macro: DMEM_BYTE_EN (byte addressing and lane enables).
module dmem_access
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    dmem_access_if.slave  bus
);

    dmem_state_t       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [3:0]        cycles_q, cycles_d;
    logic              err_q, err_d;

    logic              cnt_clr;
    logic              cnt_inc;
    logic [3:0]        cnt_sat;
    logic              cnt_tmo;

    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic [15:0]       load_data;

`ifdef DMEM_BYTE_EN
    logic [1:0]        be_q, be_d;
    logic [1:0]        req_be;

    // Byte address -> halfword address; byte stores drive both lanes.
    assign req_addr  = bus.i_addr >> 1;
    assign req_be    = bus.i_byte ? (bus.i_addr[0] ? BE_HI : BE_LO) : BE_HW;
    assign req_wdata = bus.i_byte ? {2{bus.i_wdata[7:0]}} : bus.i_wdata;

    // Byte loads return the selected lane zero-extended.
    always_comb begin
        load_data = bus.i_mem_rdata;
        case (be_q)
            BE_LO:   load_data = {8'h00, bus.i_mem_rdata[7:0]};
            BE_HI:   load_data = {8'h00, bus.i_mem_rdata[15:8]};
            default: load_data = bus.i_mem_rdata;
        endcase
    end
`else
    assign req_addr  = bus.i_addr;
    assign req_wdata = bus.i_wdata;
    assign load_data = bus.i_mem_rdata;
`endif

    dmem_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .cnt_sat_o (cnt_sat),
        .tmo_o     (cnt_tmo)
    );

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            cycles_q <= 4'd0;
            err_q    <= 1'b0;
`ifdef DMEM_BYTE_EN
            be_q     <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cycles_q <= cycles_d;
            err_q    <= err_d;
`ifdef DMEM_BYTE_EN
            be_q     <= be_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE or DONE, finish on ack or timeout.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cycles_d = cycles_q;
        err_d    = err_q;
`ifdef DMEM_BYTE_EN
        be_d     = be_q;
`endif
        cnt_clr  = 1'b1;
        cnt_inc  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.i_req) begin
                    we_d    = bus.i_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = 1'b0;
`ifdef DMEM_BYTE_EN
                    be_d    = req_be;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                cnt_clr = 1'b0;
                cnt_inc = 1'b1;
                // Ack is checked first so a last-cycle ack is not an error.
                if (bus.i_mem_ack) begin
                    if (!we_q) begin
                        rdata_d = load_data;
                    end
                    cycles_d = cnt_sat;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_tmo) begin
                    cycles_d = 4'(TIMEOUT);
                    err_d    = 1'b1;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy      = (state_q == ACCESS);
    assign bus.o_mem_en    = (state_q == ACCESS);
    assign bus.o_done      = (state_q == DONE);
    assign bus.o_err       = (state_q == DONE) && err_q;
    assign bus.o_rdata     = rdata_q;
    assign bus.o_cycles    = cycles_q;
    assign bus.o_mem_we    = we_q;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_wdata = wdata_q;
`ifdef DMEM_BYTE_EN
    assign bus.o_mem_be    = be_q;
`endif

endmodule

// File: doc/dmem_access.md
Name: dmem_access

Overview:
- Data-memory responder for the pipeline control unit.
- Accepts one load/store request from the EX/MEM stage when the control unit signals a memory addressing mode (LDR/STR).
- Drives a wait-state data-memory port until the access completes or times out, and returns read data.
- Supplies the busy/stall indication back to the stall controller, so memory stages freeze for exactly the access duration.

Parameters:
- ADDR_W, 16, width of the request address and memory address.
- TIMEOUT, 15, maximum ACCESS cycles without ack before abort (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  one-cycle request strobe (LDR/STR in EX)
- i_we  in  1  1 = store, 0 = load
- i_addr  in  ADDR_W  halfword address
- i_wdata  in  16  store data
- o_busy  out  1  access in progress (stall request)
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  one-cycle timeout pulse, coincident with o_done
- o_rdata  out  16  load result, held until next load completes
- o_cycles  out  4  ACCESS cycle count of last access, saturating at 15
- o_mem_en  out  1  memory enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  16  memory write data
- i_mem_rdata  in  16  memory read data, valid with ack
- i_mem_ack  in  1  memory completion

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE.
  - All outputs 0, including o_rdata and o_cycles.
  - Internal counter 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - When i_req=1, latch we/addr/wdata, clear the counter, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - o_mem_en=1 and o_busy=1.
  - o_mem_we, o_mem_addr and o_mem_wdata are driven from the latched request and stay stable throughout.
  - Counter increments every cycle.
- ACCESS exit on i_mem_ack=1:
  - If load, capture i_mem_rdata into o_rdata.
  - o_cycles = counter+1, saturated at 15.
  - Go to DONE.
- ACCESS exit on timeout (counter == TIMEOUT-1 and no ack):
  - Go to DONE with the err flag set.
  - o_rdata is unchanged.
  - o_cycles = TIMEOUT.
- Ack and timeout in the same cycle: ack wins and no error is flagged.
- DONE:
  - o_done=1 for one cycle; o_err = err flag; o_busy=0; o_mem_en=0.
  - Next state is IDLE, or ACCESS if i_req=1 in this cycle (back-to-back request accepted).
- Latency: req at cycle N → ACCESS from N+1 → ack at N+1 earliest → o_done at N+2.
- i_req while in ACCESS:
  - Ignored; this is a protocol violation because control is stalled.
  - Latched request is not disturbed.
- Stores never modify o_rdata.
- Reset mid-access:
  - IDLE at the next edge; o_mem_en deasserts on that edge.
  - No o_done is issued.
  - o_rdata and o_cycles are cleared.
- All outputs are registered or decoded from state only; there is no combinational path from i_mem_ack to o_busy.

Optional Feature:
- DMEM_BYTE_EN defined:
  - Adds port i_byte (in, 1) and port o_mem_be (out, 2).
  - i_addr becomes a byte address; o_mem_addr = i_addr>>1 (zero-filled MSB).
  - Byte access: o_mem_be = addr[0] ? 2'b10 : 2'b01.
  - Byte store replicates i_wdata[7:0] onto both lanes.
  - Byte load zero-extends the selected lane into o_rdata.
  - Halfword access: o_mem_be = 2'b11; addr[0] is ignored (forced even).
- DMEM_BYTE_EN undefined:
  - i_byte and o_mem_be do not exist.
  - Halfword addressing only; o_mem_addr = i_addr.

Decomposition:
- Package dmem_pkg holds:
  - state enum dmem_state_t {IDLE, ACCESS, DONE}.
  - Constant CYC_SAT = 4'd15.
  - Byte-enable constants BE_LO, BE_HI, BE_HW.
- One sub-module, dmem_wait_cnt:
  - 4-bit clear/increment counter with a saturating output and a timeout-compare output (compare value TIMEOUT-1).

Test Plan:
- Load, ack on the first ACCESS cycle, rdata=16'hBEEF: req@0 → mem_en@1 → o_done@2, o_rdata=16'hBEEF, o_cycles=1, o_err=0.
- Store addr=16'h0040, wdata=16'h1234, ack after 3 cycles: mem_we=1 with address and data stable for 3 cycles, o_busy high for 3 cycles, o_rdata unchanged, o_cycles=3.
- No ack, TIMEOUT=15: 15 ACCESS cycles, then o_done=1 and o_err=1 together, o_cycles=15, o_rdata held.
- Ack in the same cycle as the timeout compare: o_err=0, data captured.
- Back-to-back: second i_req during the DONE cycle → ACCESS on the next cycle, o_busy deasserted for exactly the one DONE cycle.
- rst=1 during ACCESS cycle 2: IDLE next edge, mem_en=0, no o_done, o_rdata=0. With DMEM_BYTE_EN: byte load at addr 16'h0003 with rdata=16'hAB12 → o_mem_be=2'b10, o_rdata=16'h00AB.
